tc_mul_pipe_rs: RTL and testbench
=================================

// Module: tc_mul_pipe_rs
// PURPOSE
//  Parametrised, pipelined multiplier for the TrackletCalculator datapath.
//  Supports per-operand signedness and a valid/ready handshake with full backpressure.
//  Applies an arithmetic right shift to the product, then narrows it to OUT_W by saturation or wrap.
//  Reports overflow per result and keeps a saturating overflow counter.
//  Replaces the fixed-width single-stage DSP multipliers in the TC stub-pair math.
// PARAMETERS
//  A_W        12  width of operand a
//  B_W        17  width of operand b
//  A_SIGNED   0   1: a is two's complement; 0: a is unsigned
//  B_SIGNED   1   1: b is two's complement; 0: b is unsigned
//  NUM_STAGE  1   pipeline register stages, >=1 (the multiply sits in stage 1)
//  SHIFT      0   right shift applied to the full product, 0..A_W+B_W-1
//  OUT_W      29  result width, 1..A_W+B_W+1
//  SATURATE   0   1: clamp to the OUT_W range; 0: keep the low OUT_W bits
//  CNT_W      16  width of the overflow counter
// PORTS
//  ap_clk     in   1       clock, rising edge
//  ap_rst_n   in   1       asynchronous active-low reset
//  in_valid   in   1       operand pair valid
//  in_ready   out  1       block accepts an operand pair this cycle
//  din0       in   A_W     operand a
//  din1       in   B_W     operand b
//  out_valid  out  1       result valid
//  out_ready  in   1       downstream accepts the result
//  dout       out  OUT_W   result; signed when A_SIGNED|B_SIGNED, else unsigned
//  dout_ovf   out  1       the narrowing step changed the value (saturated or wrapped)
//  ovf_cnt    out  CNT_W   count of accepted results with dout_ovf=1; sticks at all-ones
//  ovf_clr    in   1       synchronous clear of ovf_cnt
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - all stage valid bits=0; out_valid=0, dout=0, dout_ovf=0, ovf_cnt=0.
//   - A reset mid-operation discards every in-flight result; no partial output.
//  Handshake:
//   - Transfer in on in_valid&in_ready; transfer out on out_valid&out_ready.
//   - Stage k loads when it is empty or stage k+1 loads (last stage: when out_ready).
//   - in_ready = stage 1 loads. It is combinational from out_ready through the chain.
//   - Bubbles collapse.
//   - Data stays stable while out_valid=1 and out_ready=0.
//   - in_valid must not depend on in_ready.
//  Latency and throughput:
//   - With out_ready=1, a pair accepted at edge n gives out_valid=1 after edge n+NUM_STAGE-1.
//   - Sustained rate is 1 result/cycle.
//   - Up to NUM_STAGE results in flight; none lost or duplicated under any out_ready pattern.
//  Arithmetic:
//   - Extend each operand by 1 bit, zero or sign per its *_SIGNED.
//   - P = full signed product, A_W+B_W+1 bits, exact.
//   - S = P >>> SHIFT (floor, i.e. toward -inf).
//   - Signed output: SATURATE=1 clamps S to [-2^(OUT_W-1), 2^(OUT_W-1)-1]; SATURATE=0 takes S[OUT_W-1:0].
//   - Unsigned output (both operands unsigned): range is [0, 2^OUT_W-1].
//   - dout_ovf=1 iff S is outside the output range, whatever SATURATE is.
//   - Shift and narrow are computed in the last stage, or stage 1 when NUM_STAGE=1.
//  Counter:
//   - ovf_cnt increments on each output transfer carrying dout_ovf=1.
//   - It holds at 2^CNT_W-1.
//   - ovf_clr wins over a same-cycle increment: the result is 0.
// TESTING
//  1 Default params: a=4095, b=-65536 -> dout=-268369920, ovf=0, one cycle after accept.
//  2 OUT_W=16, SATURATE=1: a=4095, b=65535 -> dout=32767, ovf=1, ovf_cnt=1;
//    b=-65536 -> dout=-32768, ovf_cnt=2.
//  3 Same as 2 with SATURATE=0: a=4095, b=65535 -> dout=16'hF001 (-4095), ovf=1.
//  4 SHIFT=1, a=1, b=-3 -> dout=-2; a=3, b=3 -> dout=4.
//  5 NUM_STAGE=4, 100 random pairs, out_ready random at 50% ->
//    results in order, match the reference model, stable while stalled.
//  6 Reset pulse with 3 results in flight -> out_valid=0 at once, ovf_cnt=0,
//    first post-reset pair emerges after NUM_STAGE cycles;
//    ovf_clr together with an overflow transfer -> ovf_cnt=0.

Source files
------------

// File: rtl/tc_mul_pipe_rs.sv
// Pipelined signed/unsigned multiplier with valid/ready backpressure, arithmetic right shift,
// saturating or wrapping narrowing to OUT_W, per-result overflow flag and a sticky overflow counter.
module tc_mul_pipe_rs #(
   parameter int unsigned A_W       = 12,
   parameter int unsigned B_W       = 17,
   parameter int unsigned A_SIGNED  = 0,
   parameter int unsigned B_SIGNED  = 1,
   parameter int unsigned NUM_STAGE = 1,
   parameter int unsigned SHIFT     = 0,
   parameter int unsigned OUT_W     = 29,
   parameter int unsigned SATURATE  = 0,
   parameter int unsigned CNT_W     = 16
) (
   input  logic             ap_clk,
   input  logic             ap_rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [A_W-1:0]   din0,
   input  logic [B_W-1:0]   din1,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] dout,
   output logic             dout_ovf,
   output logic [CNT_W-1:0] ovf_cnt,
   input  logic             ovf_clr
);

   // Full product width: exact for every signedness combination.
   localparam int unsigned PW      = A_W + B_W + 1;
   localparam bit          OSIGNED = (A_SIGNED != 0) || (B_SIGNED != 0);

   logic [NUM_STAGE-1:0] vld_q;
   logic [NUM_STAGE-1:0] vin;
   logic [NUM_STAGE-1:0] ld;

   logic                 a_top, b_top;
   logic [PW-1:0]        ax, bx;
   logic signed [PW-1:0] prod;
   logic signed [PW-1:0] p_last;
   logic signed [PW-1:0] sh;
   logic [PW:0]          se;
   logic [OUT_W-1:0]     smax, smin, satv, nar;
   logic                 ovf_n;

   logic [OUT_W-1:0]     dout_q;
   logic                 ovf_q;
   logic [CNT_W-1:0]     cnt_q;

   // Operand extension and exact product.
   always_comb begin
      a_top = (A_SIGNED != 0) ? din0[A_W-1] : 1'b0;
      b_top = (B_SIGNED != 0) ? din1[B_W-1] : 1'b0;
      ax    = {{(PW - A_W){a_top}}, din0};
      bx    = {{(PW - B_W){b_top}}, din1};
      prod  = $signed(ax) * $signed(bx);
   end

   // Load chain: a stage loads when empty or when its successor loads.
   always_comb begin
      logic carry;
      carry = out_ready;
      for (int k = int'(NUM_STAGE) - 1; k >= 0; k--) begin
         carry = !vld_q[k] || carry;
         ld[k] = carry;
      end
   end

   always_comb begin
      vin    = '0;
      vin[0] = in_valid;
      for (int k = 1; k < int'(NUM_STAGE); k++) begin
         vin[k] = vld_q[k-1];
      end
   end

   assign in_ready  = ld[0];
   assign out_valid = vld_q[NUM_STAGE-1];

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         vld_q <= '0;
      end else begin
         vld_q <= (vld_q & ~ld) | (vin & ld);
      end
   end

   generate
      if (NUM_STAGE == 1) begin : g_one
         assign p_last = prod;
      end else begin : g_pipe
         logic signed [PW-1:0] p_q [NUM_STAGE-1];

         always_ff @(posedge ap_clk or negedge ap_rst_n) begin
            if (!ap_rst_n) begin
               for (int k = 0; k < int'(NUM_STAGE) - 1; k++) begin
                  p_q[k] <= '0;
               end
            end else begin
               if (ld[0] && vin[0]) begin
                  p_q[0] <= prod;
               end
               for (int k = 1; k < int'(NUM_STAGE) - 1; k++) begin
                  if (ld[k] && vin[k]) begin
                     p_q[k] <= p_q[k-1];
                  end
               end
            end
         end

         assign p_last = p_q[NUM_STAGE-2];
      end
   endgenerate

   // Shift and narrow, feeding the last stage register.
   always_comb begin
      sh   = p_last >>> SHIFT;
      se   = {sh[PW-1], sh};
      smax = '1;
      smax[OUT_W-1] = 1'b0;
      smin = '0;
      smin[OUT_W-1] = 1'b1;
      if (OSIGNED) begin
         ovf_n = !((se[PW:OUT_W-1] == '0) || (se[PW:OUT_W-1] == '1));
         satv  = se[PW] ? smin : smax;
      end else begin
         ovf_n = (se[PW:OUT_W] != '0);
         satv  = '1;
      end
      nar = (ovf_n && (SATURATE != 0)) ? satv : se[OUT_W-1:0];
   end

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         dout_q <= '0;
         ovf_q  <= 1'b0;
         cnt_q  <= '0;
      end else begin
         if (ld[NUM_STAGE-1] && vin[NUM_STAGE-1]) begin
            dout_q <= nar;
            ovf_q  <= ovf_n;
         end
         // Clear takes priority over a same-cycle increment.
         if (ovf_clr) begin
            cnt_q <= '0;
         end else if (out_valid && out_ready && ovf_q && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

   assign dout     = dout_q;
   assign dout_ovf = ovf_q;
   assign ovf_cnt  = cnt_q;

endmodule

// File: tb/tb_tc_mul_pipe_rs.sv
// Directed and randomised checks of tc_mul_pipe_rs across several parameter sets.
module tb_tc_mul_pipe_rs;

   logic clk;
   logic ap_rst_n;

   int total = 0;
   int bad   = 0;

   // Shared stimulus for the single-stage instances u0..u3.
   logic        in_valid, out_ready, ovf_clr;
   logic [11:0] a;
   logic [16:0] b;

   logic        r0, v0, f0;  logic [28:0] d0;  logic [15:0] c0;
   logic        r1, v1, f1;  logic [15:0] d1;  logic [15:0] c1;
   logic        r2, v2, f2;  logic [15:0] d2;  logic [1:0]  c2;
   logic        r3, v3, f3;  logic [28:0] d3;  logic [15:0] c3;

   // Four-stage instance u4 has its own stimulus.
   logic        in_valid4, out_ready4, ovf_clr4;
   logic [11:0] a4;
   logic [16:0] b4;
   logic        r4, v4, f4;  logic [15:0] d4;  logic [15:0] c4;

   tc_mul_pipe_rs u0 (
      .ap_clk(clk), .ap_rst_n(ap_rst_n), .in_valid(in_valid), .in_ready(r0),
      .din0(a), .din1(b), .out_valid(v0), .out_ready(out_ready), .dout(d0),
      .dout_ovf(f0), .ovf_cnt(c0), .ovf_clr(ovf_clr));

   tc_mul_pipe_rs #(.OUT_W(16), .SATURATE(1)) u1 (
      .ap_clk(clk), .ap_rst_n(ap_rst_n), .in_valid(in_valid), .in_ready(r1),
      .din0(a), .din1(b), .out_valid(v1), .out_ready(out_ready), .dout(d1),
      .dout_ovf(f1), .ovf_cnt(c1), .ovf_clr(ovf_clr));

   tc_mul_pipe_rs #(.OUT_W(16), .SATURATE(0), .CNT_W(2)) u2 (
      .ap_clk(clk), .ap_rst_n(ap_rst_n), .in_valid(in_valid), .in_ready(r2),
      .din0(a), .din1(b), .out_valid(v2), .out_ready(out_ready), .dout(d2),
      .dout_ovf(f2), .ovf_cnt(c2), .ovf_clr(ovf_clr));

   tc_mul_pipe_rs #(.SHIFT(1)) u3 (
      .ap_clk(clk), .ap_rst_n(ap_rst_n), .in_valid(in_valid), .in_ready(r3),
      .din0(a), .din1(b), .out_valid(v3), .out_ready(out_ready), .dout(d3),
      .dout_ovf(f3), .ovf_cnt(c3), .ovf_clr(ovf_clr));

   tc_mul_pipe_rs #(.NUM_STAGE(4), .SHIFT(3), .OUT_W(16), .SATURATE(1)) u4 (
      .ap_clk(clk), .ap_rst_n(ap_rst_n), .in_valid(in_valid4), .in_ready(r4),
      .din0(a4), .din1(b4), .out_valid(v4), .out_ready(out_ready4), .dout(d4),
      .dout_ovf(f4), .ovf_cnt(c4), .ovf_clr(ovf_clr4));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic signed [63:0] obs,
                      input logic signed [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference for u4: a unsigned 12b, b signed 17b, >>>3, saturate to signed 16b.
   function automatic void model4(input logic [11:0] ma, input logic [16:0] mb,
                                  output logic signed [63:0] md, output logic mo);
      longint p, s;
      p = longint'(ma) * longint'($signed(mb));
      s = p >>> 3;
      if (s > 32767) begin
         md = 32767;  mo = 1'b1;
      end else if (s < -32768) begin
         md = -32768; mo = 1'b1;
      end else begin
         md = s;      mo = 1'b0;
      end
   endfunction

   task automatic new_pair4();
      a4 = 12'($urandom_range(0, 4095));
      if ($urandom_range(0, 1) == 1) b4 = 17'($urandom);
      else                           b4 = 17'($urandom_range(0, 511) - 256);
   endtask

   logic signed [63:0] qd[$];
   logic               qo[$];

   initial begin
      logic               xi, xo, stalled, mo;
      logic signed [63:0] prev_d, md;
      int                 sent, got, mcnt;

      ap_rst_n = 1'b0;
      in_valid = 1'b0;  out_ready = 1'b1;  ovf_clr = 1'b0;  a = '0;  b = '0;
      in_valid4 = 1'b0; out_ready4 = 1'b1; ovf_clr4 = 1'b0; a4 = '0; b4 = '0;
      step();
      step();
      chk("rst_valid0", v0, 0);
      chk("rst_dout0", d0, 0);
      chk("rst_ovf0", f0, 0);
      chk("rst_cnt0", c0, 0);
      chk("rst_valid4", v4, 0);
      ap_rst_n = 1'b1;
      step();

      // A: 4095 * 65535
      in_valid = 1'b1; a = 12'd4095; b = 17'h0FFFF;
      step();
      chk("A_valid0", v0, 1);
      chk("A_dout0", $signed(d0), 268365825);
      chk("A_ovf0", f0, 0);
      chk("A_dout1", $signed(d1), 32767);
      chk("A_ovf1", f1, 1);
      chk("A_dout2", $signed(d2), -4095);
      chk("A_ovf2", f2, 1);
      chk("A_dout3", $signed(d3), 134182912);

      // B: 4095 * -65536
      b = 17'h10000;
      step();
      chk("B_dout0", $signed(d0), -268369920);
      chk("B_ovf0", f0, 0);
      chk("B_dout1", $signed(d1), -32768);
      chk("B_ovf1", f1, 1);
      chk("B_cnt1", c1, 1);
      chk("B_dout2", $signed(d2), 0);
      chk("B_ovf2", f2, 1);
      chk("B_dout3", $signed(d3), -134184960);

      // C: 1 * -3
      a = 12'd1; b = 17'h1FFFD;
      step();
      chk("C_dout0", $signed(d0), -3);
      chk("C_dout1", $signed(d1), -3);
      chk("C_ovf1", f1, 0);
      chk("C_cnt1", c1, 2);
      chk("C_dout3", $signed(d3), -2);

      // D: 3 * 3
      a = 12'd3; b = 17'd3;
      step();
      chk("D_dout2", $signed(d2), 9);
      chk("D_dout3", $signed(d3), 4);
      chk("D_ovf3", f3, 0);

      // Two more overflowing pairs push the 2-bit counter into saturation.
      a = 12'd4095; b = 17'h0FFFF;
      step();
      step();
      in_valid = 1'b0;
      step();
      chk("drain_valid1", v1, 0);
      chk("drain_cnt0", c0, 0);
      chk("drain_cnt1", c1, 4);
      chk("sat_cnt2", c2, 3);

      // Stall: result must hold and in_ready must drop.
      in_valid = 1'b1; a = 12'd4095; b = 17'h0FFFF;
      step();
      out_ready = 1'b0; a = 12'd1; b = 17'd1;
      #1;
      chk("stall_ready1", r1, 0);
      step();
      chk("stall_valid1", v1, 1);
      chk("stall_dout1", $signed(d1), 32767);
      chk("stall_dout0", $signed(d0), 268365825);
      chk("stall_cnt1", c1, 4);
      out_ready = 1'b1; ovf_clr = 1'b1;
      #1;
      chk("unstall_ready1", r1, 1);
      step();
      chk("clr_cnt1", c1, 0);
      chk("clr_cnt2", c2, 0);
      chk("clr_dout1", $signed(d1), 1);
      chk("clr_ovf1", f1, 0);
      ovf_clr = 1'b0; in_valid = 1'b0;
      step();
      chk("post_valid1", v1, 0);
      chk("post_cnt1", c1, 0);

      // Randomised flow through the 4-stage instance.
      sent = 0; got = 0; mcnt = 0; stalled = 1'b0; prev_d = '0;
      new_pair4();
      in_valid4 = 1'b1;
      for (int cyc = 0; cyc < 3000 && got < 100; cyc++) begin
         out_ready4 = 1'($urandom_range(0, 1));
         #1;
         if (stalled) begin
            chk("rand_hold_valid", v4, 1);
            chk("rand_hold_dout", $signed(d4), prev_d);
         end
         xo = v4 && out_ready4;
         xi = in_valid4 && r4;
         if (xo) begin
            chk("rand_qsize", qd.size() != 0, 1);
            if (qd.size() != 0) begin
               chk("rand_dout", $signed(d4), qd[0]);
               chk("rand_ovf", f4, qo[0]);
               if (qo[0]) mcnt++;
               void'(qd.pop_front());
               void'(qo.pop_front());
            end
            got++;
         end
         stalled = v4 && !out_ready4;
         prev_d  = $signed(d4);
         if (xi) begin
            model4(a4, b4, md, mo);
            qd.push_back(md);
            qo.push_back(mo);
         end
         step();
         if (xi) begin
            sent++;
            if (sent == 100) in_valid4 = 1'b0;
            else             new_pair4();
         end
      end
      chk("rand_got", got, 100);
      chk("rand_cnt4", c4, mcnt);

      // Three results in flight, then a mid-cycle reset.
      out_ready4 = 1'b0; in_valid4 = 1'b1; a4 = 12'd4095; b4 = 17'h0FFFF;
      step();
      step();
      step();
      in_valid4 = 1'b0;
      step();
      chk("fill_valid4", v4, 1);
      ap_rst_n = 1'b0;
      #1;
      chk("mid_rst_valid4", v4, 0);
      chk("mid_rst_cnt4", c4, 0);
      chk("mid_rst_dout1", $signed(d1), 0);
      #3;
      ap_rst_n = 1'b1;
      out_ready4 = 1'b1; in_valid4 = 1'b1; a4 = 12'd100; b4 = 17'h1FFF9;
      step();
      in_valid4 = 1'b0;
      chk("lat_e0_valid4", v4, 0);
      step();
      chk("lat_e1_valid4", v4, 0);
      step();
      chk("lat_e2_valid4", v4, 0);
      step();
      chk("lat_e3_valid4", v4, 1);
      chk("lat_dout4", $signed(d4), -88);
      chk("lat_ovf4", f4, 0);
      step();
      chk("lat_drain_valid4", v4, 0);

      // Clear coinciding with an overflow transfer on u4.
      in_valid4 = 1'b1; a4 = 12'd4095; b4 = 17'h0FFFF;
      step();
      in_valid4 = 1'b0;
      step();
      step();
      step();
      chk("clr4_pre_ovf", f4, 1);
      ovf_clr4 = 1'b1;
      step();
      ovf_clr4 = 1'b0;
      chk("clr4_cnt", c4, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
